// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the data-memory port.
// The arbiter attaches through the slave modport; requester-side logic uses master.
`timescale 1ns/1ps
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ack;
  logic        cpu_err;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic        dma_ack;
  logic        dma_err;
  logic        mem_cs;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic        owner;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, dma_req, dma_we, dma_addr,
    output cpu_ack, cpu_err, dma_ack, dma_err,
    output mem_cs, mem_we, mem_addr, owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, dma_req, dma_we, dma_addr,
    input  cpu_ack, cpu_err, dma_ack, dma_err,
    input  mem_cs, mem_we, mem_addr, owner, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting a CPU and a DMA requester access to a windowed
// data memory; out-of-window requests are answered with a one-cycle error pulse.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_22B0,
  parameter int unsigned WIN_SIZE      = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;

  state_t      state_reg, state_next;
  logic        last_owner_reg, last_owner_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;
  logic        busy_reg, busy_next;
  logic        mem_cs_reg, mem_cs_next;
  logic        mem_we_reg, mem_we_next;
  logic [9:0]  mem_addr_reg, mem_addr_next;
  logic        cpu_ack_reg, cpu_ack_next;
  logic        cpu_err_reg, cpu_err_next;
  logic        dma_ack_reg, dma_ack_next;
  logic        dma_err_reg, dma_err_next;

  logic        grant_valid;
  logic        grant_sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [32:0] sel_offset;
  logic        sel_in_win;

  // Addresses below BASE_ADDR borrow into bit 32, so one unsigned compare
  // rejects both sides of the window without wrap-around.
  always_comb begin
    grant_valid = bus.cpu_req | bus.dma_req;
    if (bus.cpu_req && bus.dma_req) begin
      grant_sel = ~last_owner_reg;
    end else begin
      grant_sel = bus.dma_req;
    end
    sel_addr   = grant_sel ? bus.dma_addr : bus.cpu_addr;
    sel_we     = grant_sel ? bus.dma_we   : bus.cpu_we;
    sel_offset = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
    sel_in_win = (sel_offset < 33'(WIN_SIZE));
  end

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    cnt_next        = cnt_reg;
    owner_next      = owner_reg;
    mem_cs_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    cpu_ack_next    = 1'b0;
    cpu_err_next    = 1'b0;
    dma_ack_next    = 1'b0;
    dma_err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next      = grant_sel;
          last_owner_next = grant_sel;
          if (sel_in_win) begin
            state_next    = ACCESS;
            cnt_next      = CNT_LOAD;
            mem_cs_next   = 1'b1;
            mem_we_next   = sel_we;
            mem_addr_next = sel_offset[9:0];
          end else begin
            state_next   = ERR;
            cpu_err_next = (grant_sel == OWN_CPU);
            dma_err_next = (grant_sel == OWN_DMA);
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          state_next   = DONE;
          cpu_ack_next = (owner_reg == OWN_CPU);
          dma_ack_next = (owner_reg == OWN_DMA);
        end else begin
          cnt_next    = cnt_reg - 4'd1;
          mem_cs_next = 1'b1;
          mem_we_next = mem_we_reg;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // last_owner resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_owner_reg <= OWN_DMA;
      cnt_reg        <= 4'd0;
      owner_reg      <= OWN_CPU;
      busy_reg       <= 1'b0;
      mem_cs_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= 10'd0;
      cpu_ack_reg    <= 1'b0;
      cpu_err_reg    <= 1'b0;
      dma_ack_reg    <= 1'b0;
      dma_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      busy_reg       <= busy_next;
      mem_cs_reg     <= mem_cs_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      cpu_ack_reg    <= cpu_ack_next;
      cpu_err_reg    <= cpu_err_next;
      dma_ack_reg    <= dma_ack_next;
      dma_err_reg    <= dma_err_next;
    end
  end

  assign bus.mem_cs   = mem_cs_reg;
  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.owner    = owner_reg;
  assign bus.busy     = busy_reg;
  assign bus.cpu_ack  = cpu_ack_reg;
  assign bus.cpu_err  = cpu_err_reg;
  assign bus.dma_ack  = dma_ack_reg;
  assign bus.dma_err  = dma_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single accesses, window edges, round-robin
// ordering and reset abort, with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_if();

  mem_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Issues one request from a single requester and records what the bus did,
  // counting cycles from the first negedge after the sampling edge.
  task automatic run_txn(input bit is_dma, input bit we, input logic [31:0] addr,
                         output int cs_cycles, output int first_cs, output int done_cyc,
                         output bit got_err, output logic [9:0] cs_addr, output logic cs_we,
                         output bit stable, output bit owner_ok, output bit stray);
    logic own_ack, own_err, oth;
    cs_cycles = 0; first_cs = -1; done_cyc = -1; got_err = 1'b0;
    cs_addr = '0; cs_we = 1'b0; stable = 1'b1; owner_ok = 1'b1; stray = 1'b0;
    if (is_dma) begin
      bus_if.dma_we = we; bus_if.dma_addr = addr; bus_if.dma_req = 1'b1;
    end else begin
      bus_if.cpu_we = we; bus_if.cpu_addr = addr; bus_if.cpu_req = 1'b1;
    end
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      own_ack = is_dma ? bus_if.dma_ack : bus_if.cpu_ack;
      own_err = is_dma ? bus_if.dma_err : bus_if.cpu_err;
      oth     = is_dma ? (bus_if.cpu_ack | bus_if.cpu_err) : (bus_if.dma_ack | bus_if.dma_err);
      if (bus_if.mem_cs) begin
        if (cs_cycles == 0) begin
          first_cs = cyc; cs_addr = bus_if.mem_addr; cs_we = bus_if.mem_we;
        end else if (bus_if.mem_addr !== cs_addr || bus_if.mem_we !== cs_we) begin
          stable = 1'b0;
        end
        cs_cycles++;
        if (bus_if.owner !== is_dma) owner_ok = 1'b0;
      end
      if (oth || (own_ack && own_err) || ((own_ack || own_err) && bus_if.mem_cs)) stray = 1'b1;
      if (own_ack || own_err) begin
        done_cyc = cyc; got_err = own_err;
      end
    end
    @(posedge clk); #1;
    if (is_dma) bus_if.dma_req = 1'b0; else bus_if.cpu_req = 1'b0;
    @(negedge clk);
    $display("txn %s we=%0d addr=%08h cs_cycles=%0d mem_addr=%03h done_cycle=%0d err=%0d",
             is_dma ? "DMA" : "CPU", we, addr, cs_cycles, cs_addr, done_cyc, got_err);
  endtask

  task automatic test_reset();
    bus_if.cpu_req = 1'b0; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = '0;
    bus_if.dma_req = 1'b0; bus_if.dma_we = 1'b0; bus_if.dma_addr = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.mem_cs !== 1'b0) begin failures++; $display("FAIL reset_mem_cs: got %b expected 0", bus_if.mem_cs); end
    checks++; if (bus_if.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b expected 0", bus_if.mem_we); end
    checks++; if (bus_if.mem_addr !== 10'h000) begin failures++; $display("FAIL reset_mem_addr: got %h expected 000", bus_if.mem_addr); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.owner !== 1'b0) begin failures++; $display("FAIL reset_owner: got %b expected 0", bus_if.owner); end
    checks++; if ({bus_if.cpu_ack, bus_if.cpu_err, bus_if.dma_ack, bus_if.dma_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_ack_err: got %b expected 0000", {bus_if.cpu_ack, bus_if.cpu_err, bus_if.dma_ack, bus_if.dma_err});
    end
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset released");
  endtask

  task automatic test_cpu_read();
    int cs_n, first, done; bit err, stab, own_ok, stray; logic [9:0] a; logic w;
    run_txn(1'b0, 1'b0, 32'h0000_22B0, cs_n, first, done, err, a, w, stab, own_ok, stray);
    checks++; if (first !== 1) begin failures++; $display("FAIL cpu_read_first_cs: got %0d expected 1", first); end
    checks++; if (cs_n !== 2) begin failures++; $display("FAIL cpu_read_cs_cycles: got %0d expected 2", cs_n); end
    checks++; if (a !== 10'h000) begin failures++; $display("FAIL cpu_read_mem_addr: got %h expected 000", a); end
    checks++; if (w !== 1'b0) begin failures++; $display("FAIL cpu_read_mem_we: got %b expected 0", w); end
    checks++; if (done !== 3 || err !== 1'b0) begin failures++; $display("FAIL cpu_read_ack: got cycle %0d err %0d expected cycle 3 err 0", done, err); end
    checks++; if (!stab || !own_ok || stray) begin failures++; $display("FAIL cpu_read_bus: got stable=%0d owner_ok=%0d stray=%0d expected 1 1 0", stab, own_ok, stray); end
    checks++; if (bus_if.busy !== 1'b0 || bus_if.mem_cs !== 1'b0) begin failures++; $display("FAIL cpu_read_idle: got busy=%b cs=%b expected 0 0", bus_if.busy, bus_if.mem_cs); end
  endtask

  task automatic test_dma_write();
    int cs_n, first, done; bit err, stab, own_ok, stray; logic [9:0] a; logic w;
    run_txn(1'b1, 1'b1, 32'h0000_26AF, cs_n, first, done, err, a, w, stab, own_ok, stray);
    checks++; if (a !== 10'h3FF) begin failures++; $display("FAIL dma_write_mem_addr: got %h expected 3ff", a); end
    checks++; if (w !== 1'b1) begin failures++; $display("FAIL dma_write_mem_we: got %b expected 1", w); end
    checks++; if (cs_n !== 2 || first !== 1) begin failures++; $display("FAIL dma_write_cs: got %0d cycles from %0d expected 2 from 1", cs_n, first); end
    checks++; if (done !== 3 || err !== 1'b0) begin failures++; $display("FAIL dma_write_ack: got cycle %0d err %0d expected cycle 3 err 0", done, err); end
    checks++; if (!stab || !own_ok || stray) begin failures++; $display("FAIL dma_write_bus: got stable=%0d owner_ok=%0d stray=%0d expected 1 1 0", stab, own_ok, stray); end
  endtask

  task automatic test_window_errors();
    logic [31:0] bad_addr [3] = '{32'h0000_22AF, 32'h0000_26B0, 32'hFFFF_FFFF};
    bit          bad_dma  [3] = '{1'b0, 1'b0, 1'b1};
    int cs_n, first, done; bit err, stab, own_ok, stray; logic [9:0] a; logic w;
    for (int i = 0; i < 3; i++) begin
      run_txn(bad_dma[i], 1'b1, bad_addr[i], cs_n, first, done, err, a, w, stab, own_ok, stray);
      checks++; if (done !== 1 || err !== 1'b1) begin failures++; $display("FAIL window_err_%0d: got cycle %0d err %0d expected cycle 1 err 1", i, done, err); end
      checks++; if (cs_n !== 0 || stray) begin failures++; $display("FAIL window_nocs_%0d: got cs_cycles=%0d stray=%0d expected 0 0", i, cs_n, stray); end
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{-1, -1, -1, -1};
    int n_acks = 0;
    bit multi = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 32'h0000_22C0;
    bus_if.dma_we = 1'b1; bus_if.dma_addr = 32'h0000_2300;
    bus_if.cpu_req = 1'b1; bus_if.dma_req = 1'b1;
    for (int cyc = 0; cyc < 60 && n_acks < 4; cyc++) begin
      @(negedge clk);
      if ((int'(bus_if.cpu_ack) + int'(bus_if.cpu_err) + int'(bus_if.dma_ack) + int'(bus_if.dma_err)) > 1) multi = 1'b1;
      if (bus_if.cpu_ack) begin order[n_acks] = 0; n_acks++; end
      else if (bus_if.dma_ack) begin order[n_acks] = 1; n_acks++; end
    end
    @(posedge clk); #1;
    bus_if.cpu_req = 1'b0; bus_if.dma_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (order[i] !== (i % 2)) begin failures++; $display("FAIL rr_order_%0d: got %0d expected %0d (0=CPU 1=DMA)", i, order[i], i % 2); end
    end
    checks++; if (multi) begin failures++; $display("FAIL rr_exclusive: got overlapping ack/err expected at most one"); end
    $display("txn round-robin order %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);
  endtask

  task automatic test_reset_mid_access();
    bit stray = 1'b0;
    int first_ack = -1, ack_cyc = -1, dma_cyc = -1;
    bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 32'h0000_22B4; bus_if.cpu_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    bus_if.dma_we = 1'b0; bus_if.dma_addr = 32'h0000_22B8; bus_if.dma_req = 1'b1;
    #1;
    checks++; if (bus_if.mem_cs !== 1'b0) begin failures++; $display("FAIL abort_mem_cs: got %b expected 0", bus_if.mem_cs); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", bus_if.busy); end
    repeat (3) begin
      @(negedge clk);
      if (bus_if.cpu_ack || bus_if.cpu_err || bus_if.dma_ack || bus_if.dma_err || bus_if.mem_cs) stray = 1'b1;
    end
    checks++; if (stray) begin failures++; $display("FAIL abort_no_ack: got ack/err/cs during reset expected none"); end
    rst = 1'b1;
    #1;
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL release_early_grant: got busy=%b expected 0", bus_if.busy); end
    for (int cyc = 1; cyc <= 20 && first_ack < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++; if (bus_if.owner !== 1'b0 || bus_if.mem_cs !== 1'b1) begin
          failures++; $display("FAIL release_first_grant: got owner=%b cs=%b expected 0 1", bus_if.owner, bus_if.mem_cs);
        end
      end
      if (bus_if.cpu_ack) begin first_ack = 0; ack_cyc = cyc; end
      else if (bus_if.dma_ack) begin first_ack = 1; ack_cyc = cyc; end
    end
    @(posedge clk); #1;
    bus_if.cpu_req = 1'b0;
    checks++; if (first_ack !== 0 || ack_cyc !== 3) begin failures++; $display("FAIL release_cpu_first: got who=%0d cycle=%0d expected 0 3", first_ack, ack_cyc); end
    for (int cyc = 1; cyc <= 20 && dma_cyc < 0; cyc++) begin
      @(negedge clk);
      if (bus_if.dma_ack) dma_cyc = cyc;
    end
    @(posedge clk); #1;
    bus_if.dma_req = 1'b0;
    @(negedge clk);
    checks++; if (dma_cyc < 0) begin failures++; $display("FAIL release_dma_served: got no dma_ack expected one"); end
    $display("txn reset-abort then CPU ack cycle %0d, DMA ack after %0d", ack_cyc, dma_cyc);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_window_errors();
    test_round_robin();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_22B0, first byte address of the data-memory window.
REQ-002 Parameter: WIN_SIZE, default 1024, window size in bytes; the window is BASE_ADDR .. BASE_ADDR+WIN_SIZE-1.
REQ-003 Parameter: ACCESS_CYCLES, default 2, legal range 1..15; number of cycles mem_cs is held per access.
REQ-004 Reset and clock: one clock; reset is asynchronous and active-low. Ports: clk (input, 1, rising-edge clock); rst (input, 1, asynchronous, active-low).
REQ-005 cpu_req  input  1  CPU access request, level.
REQ-006 cpu_we  input  1  CPU write enable, qualified by cpu_req.
REQ-007 cpu_addr  input  32  CPU byte address.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 cpu_err  output  1  one-cycle out-of-window pulse to CPU.
REQ-010 dma_req, dma_we, dma_addr[31:0], dma_ack, dma_err  same directions, widths and meanings for the DMA/IO requester.
REQ-011 mem_cs  output  1  memory chip select.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  10  window-relative address.
REQ-014 owner  output  1  0=CPU, 1=DMA; valid while busy.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE and ERR; all outputs SHALL be registered.
REQ-017 IDLE: with no request, stay in IDLE; with one request, grant it; with both, grant the requester not granted last (round-robin via a last_owner register).
REQ-018 On grant, the arbiter SHALL latch the owner's address and we, and set owner.
REQ-019 On grant with an in-window address, go to ACCESS; with an out-of-window address, go to ERR.
REQ-020 ACCESS: mem_cs=1 for exactly ACCESS_CYCLES consecutive cycles.
REQ-021 ACCESS: mem_we = latched we; mem_addr = (latched addr - BASE_ADDR)[9:0], stable for the whole access; a down-counter sets the cycle count; exit to DONE.
REQ-022 DONE: the owner's ack=1 for one cycle, mem_cs=0, mem_we=0; next state IDLE.
REQ-023 ERR: the owner's err=1 for one cycle; mem_cs, mem_we and ack stay 0; next state IDLE.
REQ-024 last_owner SHALL update on every grant, including grants that lead to ERR.
REQ-025 Latency: request sampled in IDLE at edge N; mem_cs high in cycles N+1 .. N+ACCESS_CYCLES; ack in cycle N+ACCESS_CYCLES+1.
REQ-026 Handshake: a requester holds req, we and addr until it samples its ack or err high, then drops req on the next edge. Changes to the non-granted requester's inputs SHALL have no effect.
REQ-027 Window bounds: addresses BASE_ADDR and BASE_ADDR+WIN_SIZE-1 are in-window. BASE_ADDR-1 and BASE_ADDR+WIN_SIZE are errors, with no wrap-around; the comparison is 32-bit unsigned.
REQ-028 Idle outputs: never more than one of cpu_ack, cpu_err, dma_ack, dma_err is high in any cycle, and mem_cs=0 in IDLE, DONE and ERR.

Reset
REQ-029 While rst=0: state=IDLE, last_owner=DMA (so the CPU wins the first tie), counter=0, and mem_cs, mem_we, mem_addr, acks, errs, busy and owner all 0.
REQ-030 Reset asserted mid-ACCESS SHALL drop mem_cs immediately (asynchronously), and the aborted access SHALL produce no ack or err.
REQ-031 After rst rises, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-032 CPU read, cpu_addr=32'h22B0, ACCESS_CYCLES=2 -> mem_cs high 2 cycles with mem_addr=10'h000 and mem_we=0; cpu_ack in cycle 3.
REQ-033 DMA write, dma_addr=32'h26AF -> mem_addr=10'h3FF, mem_we=1 during ACCESS, then a dma_ack pulse.
REQ-034 Simultaneous cpu_req and dma_req held high after reset, 4 transactions -> grant order CPU, DMA, CPU, DMA.
REQ-035 cpu_addr=32'h22AF, then 32'h26B0 -> a cpu_err pulse each time, with mem_cs never high.
REQ-036 rst driven low in the second ACCESS cycle -> mem_cs=0 in the same cycle with no ack. After release, a pending dma_req and cpu_req -> CPU granted first.
